// File: rtl/ghost_collision_if.sv
// Position and status bundle between the movers and the ghost/Pac-Man collision block.
// The master drives positions and the movement strobe; the slave returns collision status.
interface ghost_collision_if;
  logic       tick;
  logic [9:0] pac_x;
  logic [8:0] pac_y;
  logic [9:0] ghost_x;
  logic [8:0] ghost_y;
  logic       hit;
  logic       respawn;
  logic       freeze;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    output tick, pac_x, pac_y, ghost_x, ghost_y,
    input  hit, respawn, freeze, lives, game_over
  );

  modport slave (
    input  tick, pac_x, pac_y, ghost_x, ghost_y,
    output hit, respawn, freeze, lives, game_over
  );
endinterface

// File: rtl/ghost_collision.sv
// Ghost/Pac-Man overlap detection, lives bookkeeping and the freeze/respawn sequence.
// Every output is registered; the overlap test is registered one cycle ahead of the FSM.
module ghost_collision #(
  parameter int unsigned HIT_RADIUS   = 8,
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned FREEZE_TICKS = 120
) (
  input  logic             clk,
  input  logic             rst,
  ghost_collision_if.slave bus
);

  localparam logic [10:0] RAD_X  = 11'(HIT_RADIUS);
  localparam logic [9:0]  RAD_Y  = 10'(HIT_RADIUS);
  localparam logic [1:0]  LIVES0 = 2'(LIVES_INIT);
  localparam logic [7:0]  TICKS0 = 8'(FREEZE_TICKS);

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    HIT    = 2'd1,
    FREEZE = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] lives_q, lives_d;
  logic       overlap_q, overlap_d;
  logic       hit_q, hit_d;
  logic       respawn_q, respawn_d;
  logic       freeze_q, freeze_d;
  logic       over_q, over_d;

  logic [10:0] dx, adx;
  logic [9:0]  dy, ady;

  // Zero-extended subtraction: the playfield never wraps, so 0 vs 1023 is far apart.
  assign dx  = {1'b0, bus.ghost_x} - {1'b0, bus.pac_x};
  assign dy  = {1'b0, bus.ghost_y} - {1'b0, bus.pac_y};
  assign adx = dx[10] ? (~dx + 11'd1) : dx;
  assign ady = dy[9]  ? (~dy + 10'd1) : dy;
  assign overlap_d = (adx < RAD_X) && (ady < RAD_Y);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    unique case (state_q)
      PLAY: begin
        if (overlap_q) begin
          state_d = HIT;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end
      end
      HIT: begin
        if (lives_q == 2'd0) begin
          state_d = OVER;
        end else begin
          state_d = FREEZE;
          cnt_d   = TICKS0;
        end
      end
      FREEZE: begin
        if (cnt_q == 8'd0) begin
          state_d = PLAY;
        end else if (bus.tick) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = PLAY;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    hit_d     = (state_q == PLAY) && (state_d == HIT);
    respawn_d = (state_q == HIT) && (state_d == FREEZE);
    freeze_d  = (state_d != PLAY);
    over_d    = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PLAY;
      cnt_q     <= '0;
      lives_q   <= LIVES0;
      overlap_q <= 1'b0;
      hit_q     <= 1'b0;
      respawn_q <= 1'b0;
      freeze_q  <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lives_q   <= lives_d;
      overlap_q <= overlap_d;
      hit_q     <= hit_d;
      respawn_q <= respawn_d;
      freeze_q  <= freeze_d;
      over_q    <= over_d;
    end
  end

  assign bus.hit       = hit_q;
  assign bus.respawn   = respawn_q;
  assign bus.freeze    = freeze_q;
  assign bus.lives     = lives_q;
  assign bus.game_over = over_q;

endmodule
